alu_op_sequencer: RTL and testbench

Front-end controller for the `ArithmeticLogicUnit`. It accepts operation requests over a valid/ready handshake, drives the ALU's operand, `FunSel` and `WF` inputs, and captures `ALUOut` and `FlagsOut`. It returns them as a response over a second valid/ready handshake. The ALU shifts by only one position per operation, so the block also sequences multi-position shifts and rotates by re-issuing the ALU operation with the previous result fed back as A.

---
 rtl/alu_op_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready front end for the ArithmeticLogicUnit.
// Accepts one request, drives the ALU operands/FunSel/WF, captures
// AluOut/AluFlags and returns them as a response. Multi-position shifts
// and rotates re-issue the same one-position ALU op, feeding the previous
// result back as A.
//
// Ports:
//   Clock, Reset            clock, synchronous active-high reset
//   ReqValid/ReqReady       request handshake
//   ReqFunSel, ReqWF        ALU function (bit 4 = 32-bit mode), flag write
//   ReqA, ReqB, ReqCount    operands and shift repeat count
//   AluA, AluB, AluFunSel,
//   AluWF                   ALU drive (registered)
//   AluOut, AluFlags        ALU result and {Z,C,N,O} flags
//   RspValid/RspReady       response handshake
//   RspData, RspFlags       final result and flags
//   Busy                    high outside IDLE
module alu_op_sequencer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 5
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             ReqValid,
   output logic             ReqReady,
   input  logic [4:0]       ReqFunSel,
   input  logic             ReqWF,
   input  logic [WIDTH-1:0] ReqA,
   input  logic [WIDTH-1:0] ReqB,
   input  logic [CNT_W-1:0] ReqCount,
   output logic [WIDTH-1:0] AluA,
   output logic [WIDTH-1:0] AluB,
   output logic [4:0]       AluFunSel,
   output logic             AluWF,
   input  logic [WIDTH-1:0] AluOut,
   input  logic [3:0]       AluFlags,
   output logic             RspValid,
   input  logic             RspReady,
   output logic [WIDTH-1:0] RspData,
   output logic [3:0]       RspFlags,
   output logic             Busy
);

   localparam int unsigned FS_W   = 5;
   localparam int unsigned FLAG_W = 4;
   // FunSel[3:0] codes at or above this value are shift/rotate functions
   localparam logic [3:0]  SHIFT_LO = 4'b1011;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    res_q, res_d;
   logic [FLAG_W-1:0]   flags_q, flags_d;
   logic [WIDTH-1:0]    b_q, b_d;
   logic [FS_W-1:0]     fs_q, fs_d;
   logic                wf_q, wf_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic [WIDTH-1:0]    alu_a_q, alu_a_d;
   logic [WIDTH-1:0]    alu_b_q, alu_b_d;
   logic [FS_W-1:0]     alu_fs_q, alu_fs_d;
   logic                alu_wf_q, alu_wf_d;
   logic                req_ready_q, req_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                busy_q, busy_d;

   // State, datapath and registered output drive
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= IDLE;
         res_q       <= '0;
         flags_q     <= '0;
         b_q         <= '0;
         fs_q        <= '0;
         wf_q        <= 1'b0;
         cnt_q       <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_fs_q    <= '0;
         alu_wf_q    <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         res_q       <= res_d;
         flags_q     <= flags_d;
         b_q         <= b_d;
         fs_q        <= fs_d;
         wf_q        <= wf_d;
         cnt_q       <= cnt_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_fs_q    <= alu_fs_d;
         alu_wf_q    <= alu_wf_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d  = state_q;
      res_d    = res_q;
      flags_d  = flags_q;
      b_d      = b_q;
      fs_d     = fs_q;
      wf_d     = wf_q;
      cnt_d    = cnt_q;
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      // Pass-A with WF low keeps the ALU's flags (and chained C) intact
      alu_fs_d = {fs_q[4], 4'b0000};
      alu_wf_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (ReqValid) begin
               res_d = ReqA;
               b_d   = ReqB;
               wf_d  = ReqWF;
               fs_d  = ReqFunSel;
               cnt_d = CNT_W'(1);
               if (ReqFunSel[3:0] >= SHIFT_LO) begin
                  // A zero-count shift becomes one pass-A step
                  if (ReqCount == '0) begin
                     fs_d = {ReqFunSel[4], 4'b0000};
                  end else begin
                     cnt_d = ReqCount;
                  end
               end
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            res_d   = AluOut;
            flags_d = AluFlags;
            cnt_d   = cnt_q - CNT_W'(1);
            state_d = (cnt_q > CNT_W'(1)) ? ISSUE : RESP;
         end
         RESP: begin
            if (RspReady) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Operand drive is set up one cycle ahead so it is valid during ISSUE
      if (state_d == ISSUE) begin
         alu_a_d  = res_d;
         alu_b_d  = b_d;
         alu_fs_d = fs_d;
         alu_wf_d = wf_d;
      end
   end

   assign req_ready_d = (state_d == IDLE);
   assign rsp_valid_d = (state_d == RESP);
   assign busy_d      = (state_d != IDLE);

   assign ReqReady  = req_ready_q;
   assign RspValid  = rsp_valid_q;
   assign Busy      = busy_q;
   assign AluA      = alu_a_q;
   assign AluB      = alu_b_q;
   assign AluFunSel = alu_fs_q;
   assign AluWF     = alu_wf_q;
   assign RspData   = res_q;
   assign RspFlags  = flags_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU model.
module tb_alu_op_sequencer;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        ReqValid;
   logic        ReqReady;
   logic [4:0]  ReqFunSel;
   logic        ReqWF;
   logic [31:0] ReqA, ReqB;
   logic [4:0]  ReqCount;
   logic [31:0] AluA, AluB;
   logic [4:0]  AluFunSel;
   logic        AluWF;
   logic [31:0] AluOut = '0;
   logic [3:0]  AluFlags;
   logic        RspValid;
   logic        RspReady;
   logic [31:0] RspData;
   logic [3:0]  RspFlags;
   logic        Busy;

   alu_op_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
      .Clock(Clock), .Reset(Reset),
      .ReqValid(ReqValid), .ReqReady(ReqReady),
      .ReqFunSel(ReqFunSel), .ReqWF(ReqWF),
      .ReqA(ReqA), .ReqB(ReqB), .ReqCount(ReqCount),
      .AluA(AluA), .AluB(AluB), .AluFunSel(AluFunSel), .AluWF(AluWF),
      .AluOut(AluOut), .AluFlags(AluFlags),
      .RspValid(RspValid), .RspReady(RspReady),
      .RspData(RspData), .RspFlags(RspFlags), .Busy(Busy)
   );

   always #5 Clock = ~Clock;

   int n_tests = 0;
   int n_fail  = 0;

   // One-position ALU: returns {Z,C,N,O, result}
   function automatic logic [35:0] alu_f(input logic [4:0] fs, input logic [31:0] a,
                                         input logic [31:0] b, input logic [3:0] fl);
      logic [32:0] s;
      logic [31:0] am, bm, r;
      logic c, o, cin;
      int m;
      m   = fs[4] ? 31 : 15;
      am  = fs[4] ? a : {16'h0, a[15:0]};
      bm  = fs[4] ? b : {16'h0, b[15:0]};
      cin = fl[2];
      c   = cin;
      o   = fl[0];
      r   = am;
      s   = '0;
      case (fs[3:0])
         4'b0000: r = am;
         4'b0100: begin
            s = {1'b0, am} + {1'b0, bm};
            r = s[31:0];
            c = fs[4] ? s[32] : s[16];
            o = (am[m] == bm[m]) && (r[m] != am[m]);
         end
         4'b1011: begin c = am[m]; r = am << 1; end
         4'b1100: begin c = am[0]; r = am >> 1; end
         4'b1101: begin c = am[0]; r = am >> 1; r[m] = am[m]; end
         4'b1110: begin c = am[m]; r = (am << 1) | {31'b0, cin}; end
         4'b1111: begin c = am[0]; r = am >> 1; r[m] = cin; end
         default: r = am ^ bm;
      endcase
      if (!fs[4]) r[31:16] = 16'h0;
      return {(r == 32'h0), c, r[m], o, r};
   endfunction

   // ALU model: samples drive at each edge, result/flags visible next cycle
   logic [3:0]  alu_flags = 4'h0;
   logic [35:0] alu_nx;
   int          wf_cnt = 0;
   logic [31:0] a_log  [256];
   logic [4:0]  fs_log [256];

   assign alu_nx   = alu_f(AluFunSel, AluA, AluB, alu_flags);
   assign AluFlags = alu_flags;

   always @(posedge Clock) begin
      AluOut <= alu_nx[31:0];
      if (AluWF === 1'b1) begin
         alu_flags <= alu_nx[35:32];
         a_log[wf_cnt[7:0]]  <= AluA;
         fs_log[wf_cnt[7:0]] <= AluFunSel;
         wf_cnt <= wf_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   int          base;
   int          lat;
   logic [31:0] exp_data;
   logic [3:0]  exp_flags;
   int          exp_n;

   // Issue one request, predict its outcome, wait for the response and check it
   task automatic run_op(input logic [4:0] fs, input logic wf, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] cnt);
      int guard;
      logic [4:0] fse;
      int n;
      logic [35:0] m;
      logic [31:0] r;
      logic [3:0] f;
      @(negedge Clock);
      ReqFunSel = fs; ReqWF = wf; ReqA = a; ReqB = b; ReqCount = cnt; ReqValid = 1'b1;
      guard = 0;
      while (ReqReady !== 1'b1 && guard < 50) begin
         @(negedge Clock);
         guard++;
      end
      chk("req_ready", 64'(ReqReady), 64'(1));
      f    = alu_flags;
      base = wf_cnt;
      fse  = fs;
      n    = 1;
      if (fs[3:0] >= 4'b1011) begin
         if (cnt == 5'd0) fse = {fs[4], 4'b0000};
         else n = int'(cnt);
      end
      r = a;
      for (int i = 0; i < n; i++) begin
         m = alu_f(fse, r, b, f);
         r = m[31:0];
         if (wf) f = m[35:32];
      end
      exp_data = r; exp_flags = f; exp_n = n;
      @(posedge Clock);
      @(negedge Clock);
      ReqValid = 1'b0;
      lat = 1;
      while (RspValid !== 1'b1 && lat < 200) begin
         @(negedge Clock);
         lat++;
      end
      chk("latency", 64'(lat), 64'(2 * n + 1));
      chk("rsp_data", 64'(RspData), 64'(exp_data));
      chk("rsp_flags", 64'(RspFlags), 64'(exp_flags));
      chk("wf_pulses", 64'(wf_cnt - base), 64'(wf ? n : 0));
   endtask

   // Consume the response after some backpressure cycles
   task automatic respond(input int delay);
      repeat (delay) @(negedge Clock);
      if (delay > 0) chk("rsp_hold", 64'(RspData), 64'(exp_data));
      RspReady = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      RspReady = 1'b0;
      chk("idle_after_rsp", 64'(Busy), 64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] ops [8];
      int b1, guard;
      ops = '{4'b0000, 4'b0100, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b0001};
      Reset = 1'b1; ReqValid = 1'b0; ReqFunSel = '0; ReqWF = 1'b0;
      ReqA = '0; ReqB = '0; ReqCount = '0; RspReady = 1'b0;
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b0;

      // Single ADD
      run_op(5'b10100, 1'b1, 32'd5, 32'd7, 5'd0);
      chk("add_data", 64'(RspData), 64'(12));
      chk("add_z", 64'(RspFlags[3]), 64'(0));
      chk("add_funsel", 64'(fs_log[8'(base)]), 64'(5'b10100));
      respond(0);

      // Reset for 3 cycles while idle
      @(negedge Clock);
      Reset = 1'b1;
      repeat (3) @(negedge Clock);
      chk("rst_ctl", 64'({RspValid, Busy, AluWF, AluFunSel}), 64'(0));
      chk("rst_alu", 64'({AluA, AluB}), 64'(0));
      chk("rst_rsp", 64'({RspData, RspFlags}), 64'(0));
      Reset = 1'b0;
      @(negedge Clock);
      chk("rst_rel_ready", 64'(ReqReady), 64'(1));
      chk("rst_rel_busy", 64'(Busy), 64'(0));

      // Four-position LSL
      run_op(5'b11011, 1'b1, 32'h1, 32'h0, 5'd4);
      chk("lsl_data", 64'(RspData), 64'(32'h10));
      for (int i = 0; i < 4; i++) chk("lsl_alu_a", 64'(a_log[8'(base + i)]), 64'(32'h1 << i));
      respond(1);

      // Zero-count shift issues a single pass-A
      run_op(5'b11100, 1'b1, 32'h80, 32'h0, 5'd0);
      chk("zero_funsel", 64'(fs_log[8'(base)]), 64'(5'b10000));
      chk("zero_data", 64'(RspData), 64'(32'h80));
      respond(0);

      // Backpressure with ReqValid pulsing
      run_op(5'b10100, 1'b1, 32'd3, 32'd4, 5'd0);
      b1 = wf_cnt;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clock);
         ReqValid = i[0];
         ReqA = $urandom;
         chk("bp_ready", 64'(ReqReady), 64'(0));
         chk("bp_data", 64'(RspData), 64'(exp_data));
         chk("bp_flags", 64'(RspFlags), 64'(exp_flags));
      end
      @(negedge Clock);
      ReqValid = 1'b0;
      chk("bp_no_wf", 64'(wf_cnt - b1), 64'(0));
      RspReady = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      RspReady = 1'b0;
      chk("bp_rel_busy", 64'(Busy), 64'(0));
      chk("bp_rel_ready", 64'(ReqReady), 64'(1));
      @(negedge Clock);
      chk("bp_no_accept", 64'(Busy), 64'(0));

      // Reset during the 3rd ISSUE cycle of a 10-step shift
      @(negedge Clock);
      ReqFunSel = 5'b11011; ReqWF = 1'b1; ReqA = $urandom; ReqB = '0;
      ReqCount = 5'd10; ReqValid = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      ReqValid = 1'b0;
      base = wf_cnt;
      guard = 0;
      while (!(AluWF === 1'b1 && (wf_cnt - base) == 2) && guard < 50) begin
         @(negedge Clock);
         guard++;
      end
      chk("mid_third_issue", 64'(AluWF), 64'(1));
      Reset = 1'b1;
      @(negedge Clock);
      chk("mid_busy", 64'(Busy), 64'(0));
      chk("mid_rspvalid", 64'(RspValid), 64'(0));
      chk("mid_wf", 64'(AluWF), 64'(0));
      Reset = 1'b0;
      b1 = wf_cnt;
      repeat (25) @(negedge Clock);
      chk("mid_no_wf", 64'(wf_cnt - b1), 64'(0));
      chk("mid_pulses", 64'(b1 - base), 64'(3));

      // Randomized operations
      for (int k = 0; k < 40; k++) begin
         run_op({1'($urandom_range(0, 1)), ops[$urandom_range(0, 7)]},
                1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 6)));
         respond(int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
